// File: rtl/inv_mixcol_seq.sv
// Iterative AES InvMixColumns engine: one shared column unit processes the
// 128-bit state one 32-bit column per cycle over four cycles. A bypass flag
// passes the state through untouched for the final decryption round.
module inv_mixcol_seq (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic         in_bypass,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} st_e;

   st_e          st_q, st_d;
   logic [127:0] state_q, state_d;
   logic [1:0]   col_cnt_q, col_cnt_d;
   logic         bypass_q, bypass_d;
   logic [31:0]  col_in, col_out;

   // Multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] a);
      return xt(xt(xt(a))) ^ a;
   endfunction

   function automatic logic [7:0] mulb(input logic [7:0] a);
      return xt(xt(xt(a))) ^ xt(a) ^ a;
   endfunction

   function automatic logic [7:0] muld(input logic [7:0] a);
      return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
   endfunction

   function automatic logic [7:0] mule(input logic [7:0] a);
      return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
   endfunction

   // Select the column currently being processed.
   always_comb begin
      col_in = '0;
      unique case (col_cnt_q)
         2'd0: col_in = state_q[31:0];
         2'd1: col_in = state_q[63:32];
         2'd2: col_in = state_q[95:64];
         2'd3: col_in = state_q[127:96];
         default: col_in = '0;
      endcase
   end

   // Shared inverse column unit: four row multipliers over bytes a0..a3.
   always_comb begin
      logic [7:0] a0, a1, a2, a3;
      a0 = col_in[7:0];
      a1 = col_in[15:8];
      a2 = col_in[23:16];
      a3 = col_in[31:24];
      col_out[7:0]   = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
      col_out[15:8]  = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
      col_out[23:16] = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
      col_out[31:24] = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
   end

   // Next-state, column write-back and handshake outputs.
   always_comb begin
      st_d      = st_q;
      state_d   = state_q;
      col_cnt_d = col_cnt_q;
      bypass_d  = bypass_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (st_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d   = in_state;
               bypass_d  = in_bypass;
               col_cnt_d = 2'd0;
               st_d      = in_bypass ? StDone : StBusy;
            end
         end
         StBusy: begin
            busy = 1'b1;
            // A bypassed state never reaches BUSY; the guard keeps it untouched regardless.
            if (!bypass_q) begin
               unique case (col_cnt_q)
                  2'd0: state_d[31:0]   = col_out;
                  2'd1: state_d[63:32]  = col_out;
                  2'd2: state_d[95:64]  = col_out;
                  2'd3: state_d[127:96] = col_out;
                  default: ;
               endcase
            end
            col_cnt_d = col_cnt_q + 2'd1;
            if (col_cnt_q == 2'd3) st_d = StDone;
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) st_d = StIdle;
         end
         default: st_d = StIdle;
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= StIdle;
         state_q   <= '0;
         col_cnt_q <= 2'd0;
         bypass_q  <= 1'b0;
      end else begin
         st_q      <= st_d;
         state_q   <= state_d;
         col_cnt_q <= col_cnt_d;
         bypass_q  <= bypass_d;
      end
   end

   assign out_state = state_q;

endmodule

// File: tb/tb_inv_mixcol_seq.sv
module tb_inv_mixcol_seq;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         in_bypass;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic         busy;

   int total = 0;
   int bad   = 0;

   inv_mixcol_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .in_bypass (in_bypass),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [127:0] MixIn  = {32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e};
   localparam logic [127:0] MixOut = {32'hc6c6c6c6, 32'h01010101, 32'h5c220af2, 32'h455313db};

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_state = '0; in_bypass = 1'b0; out_ready = 1'b0;
      #3;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (out_state !== 128'h0) begin bad++; $display("FAIL reset_out_state got=%h want=0", out_state); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Normal transaction with out_ready held high; checks timing and result.
   task automatic test_normal(input string nm, input logic [127:0] st, input logic [127:0] exp);
      int k;
      int busy_cnt;
      bit ir_low;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL %s_idle got in_ready=%b out_valid=%b want 1/0", nm, in_ready, out_valid);
      end
      in_valid = 1'b1; in_state = st; in_bypass = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_state = '0;
      k = 1; busy_cnt = 0; ir_low = 1'b1;
      while (!out_valid && k < 20) begin
         if (busy) busy_cnt++;
         if (in_ready) ir_low = 1'b0;
         @(negedge clk);
         k++;
      end
      total++; if (k - 1 != 4) begin bad++; $display("FAIL %s_latency got=%0d want=4", nm, k - 1); end
      total++; if (busy_cnt != 4) begin bad++; $display("FAIL %s_busy_cycles got=%0d want=4", nm, busy_cnt); end
      total++; if (out_state !== exp) begin bad++; $display("FAIL %s_result got=%h want=%h", nm, out_state, exp); end
      total++; if (!ir_low || in_ready !== 1'b0) begin
         bad++; $display("FAIL %s_in_ready_low got=%b want=0", nm, in_ready);
      end
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL %s_post_handshake got out_valid=%b in_ready=%b want 0/1", nm, out_valid, in_ready);
      end
   endtask

   task automatic test_bypass();
      logic [127:0] d;
      d = 128'h0123456789abcdeffedcba9876543210;
      in_valid = 1'b1; in_state = d; in_bypass = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0; in_bypass = 1'b0; in_state = '0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bypass_valid got=%b want=1", out_valid); end
      total++; if (out_state !== d) begin bad++; $display("FAIL bypass_data got=%h want=%h", out_state, d); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL bypass_busy got=%b want=0", busy); end
      out_ready = 1'b1;
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL bypass_handshake got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_backpressure();
      int k;
      bit stable;
      in_valid = 1'b1; in_state = MixIn; in_bypass = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 20) begin @(negedge clk); k++; end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_reach_done got=%b want=1", out_valid); end
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid  = ~in_valid;
         in_state  = {$urandom, $urandom, $urandom, $urandom};
         in_bypass = i[0];
         @(negedge clk);
         if (out_valid !== 1'b1 || out_state !== MixOut || in_ready !== 1'b0) stable = 1'b0;
      end
      total++; if (!stable) begin
         bad++; $display("FAIL bp_hold got valid=%b state=%h ready=%b want 1/%h/0", out_valid, out_state, in_ready, MixOut);
      end
      in_valid = 1'b0; in_bypass = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] sa, sb, ea, eb;
      logic [127:0] outs [2];
      int acc [2];
      int n_acc, n_out;
      sa = {4{32'hbca14d8e}}; ea = {4{32'h455313db}};
      sb = {4{32'h9d58dc9f}}; eb = {4{32'h5c220af2}};
      n_acc = 0; n_out = 0; acc[0] = 0; acc[1] = 0;
      in_valid = 1'b1; in_state = sa; in_bypass = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 40 && n_out < 2; i++) begin
         if (out_valid) begin outs[n_out] = out_state; n_out++; end
         if (in_ready && in_valid && n_acc < 2) begin
            acc[n_acc] = i; n_acc++;
         end else if (!in_ready && n_acc == 1) begin
            in_state = sb;
         end else if (!in_ready && n_acc == 2) begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      total++; if (n_acc != 2 || acc[1] - acc[0] != 6) begin
         bad++; $display("FAIL b2b_spacing got accepts=%0d gap=%0d want 2/6", n_acc, acc[1] - acc[0]);
      end
      total++; if (n_out != 2) begin bad++; $display("FAIL b2b_outputs got=%0d want=2", n_out); end
      else begin
         total++; if (outs[0] !== ea) begin bad++; $display("FAIL b2b_first got=%h want=%h", outs[0], ea); end
         total++; if (outs[1] !== eb) begin bad++; $display("FAIL b2b_second got=%h want=%h", outs[1], eb); end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; in_state = MixIn; in_bypass = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL rstmid_ctrl got valid=%b ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
      end
      total++; if (out_state !== 128'h0) begin bad++; $display("FAIL rstmid_state got=%h want=0", out_state); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_normal("after_rst", {4{32'hbca14d8e}}, {4{32'h455313db}});
   endtask

   initial begin
      test_reset();
      test_normal("col_bca1", {4{32'hbca14d8e}}, {4{32'h455313db}});
      test_normal("col_9d58", {4{32'h9d58dc9f}}, {4{32'h5c220af2}});
      test_normal("col_0101", {4{32'h01010101}}, {4{32'h01010101}});
      test_normal("col_c6c6", {4{32'hc6c6c6c6}}, {4{32'hc6c6c6c6}});
      test_normal("mixed", MixIn, MixOut);
      test_bypass();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
